hazard_fwd_unit: RTL and testbench

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_scoreboard.sv | 63 ++++++
 rtl/hazard_fwd_unit.sv | 138 +++++++++++++
 tb/tb_hazard_fwd_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding unit: load-use FSM states and
// operand forwarding-mux select encodings.
package hazard_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LSTALL = 1'b1
    } lu_state_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    localparam int CNT_W  = 3;  // holds LOAD_LAT-1 for LOAD_LAT up to 7
    localparam int PEND_W = 4;  // holds MAX_PEND up to 15

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register busy bits and outstanding-write counter for multicycle ops
// that write back out of order with respect to the main pipeline.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int AW        = 5,
    parameter int NOFWD_REG = 31,
    parameter int MAX_PEND  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mc_issue,
    input  logic [AW-1:0]        mc_rd,
    input  logic                 mc_done,
    input  logic [AW-1:0]        mc_done_rd,
    output logic [(1<<AW)-1:0]   busy,
    output logic [PEND_W-1:0]    mc_pending,
    output logic                 mc_full
);

    localparam int NREG = 1 << AW;
    localparam logic [AW-1:0] NOFWD = AW'(NOFWD_REG);

    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   set_mask;
    logic [NREG-1:0]   clr_mask;
    logic [PEND_W-1:0] pend_q;
    logic              done_ok;
    logic              issue_ok;

    // Only a retirement whose bit is actually set counts, so the counter can never wrap.
    assign done_ok  = mc_done && busy_q[mc_done_rd] && (pend_q != '0);
    assign mc_full  = (pend_q == PEND_W'(MAX_PEND));
    // A retirement in the same cycle frees a slot, so a full scoreboard can still accept.
    assign issue_ok = mc_issue && (mc_rd != NOFWD) && (!mc_full || done_ok);

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_ok) set_mask[mc_rd]      = 1'b1;
        if (done_ok)  clr_mask[mc_done_rd] = 1'b1;
    end

    // NOTE: the busy bits are plain flops, not a RAM, so they reset with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_mask) | set_mask;  // set wins over clear
            if (issue_ok && !done_ok) begin
                pend_q <= pend_q + PEND_W'(1);
            end else if (!issue_ok && done_ok) begin
                pend_q <= pend_q - PEND_W'(1);
            end
        end
    end

    assign busy       = busy_q;
    assign mc_pending = pend_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard unit: EX operand forwarding, load-use stall FSM,
// multicycle scoreboard stalls and branch flush.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int AW        = 5,
    parameter int NSRC      = 2,
    parameter int NOFWD_REG = 31,
    parameter int LOAD_LAT  = 1,
    parameter int MAX_PEND  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic [NSRC-1:0]      id_src_vld,
    input  logic [NSRC*AW-1:0]   ex_src,
    input  logic [AW-1:0]        ex_rd,
    input  logic [AW-1:0]        mem_rd,
    input  logic [AW-1:0]        wb_rd,
    input  logic                 ex_regwrite,
    input  logic                 mem_regwrite,
    input  logic                 wb_regwrite,
    input  logic                 ex_memread,
    input  logic                 mc_issue,
    input  logic [AW-1:0]        mc_rd,
    input  logic                 mc_done,
    input  logic [AW-1:0]        mc_done_rd,
    input  logic                 branch_taken,
    output logic [2*NSRC-1:0]    fwd_sel,
    output logic                 stall,
    output logic                 bubble,
    output logic                 flush,
    output logic                 mc_full,
    output logic [PEND_W-1:0]    mc_pending
);

    localparam logic [AW-1:0] NOFWD = AW'(NOFWD_REG);

    logic [(1<<AW)-1:0] busy;
    logic               lu_hit;
    logic               sb_hit;
    logic               lat_stall;
    lu_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    hazard_scoreboard #(
        .AW        (AW),
        .NOFWD_REG (NOFWD_REG),
        .MAX_PEND  (MAX_PEND)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .mc_issue   (mc_issue),
        .mc_rd      (mc_rd),
        .mc_done    (mc_done),
        .mc_done_rd (mc_done_rd),
        .busy       (busy),
        .mc_pending (mc_pending),
        .mc_full    (mc_full)
    );

    // MEM holds the younger result, so it is checked before WB.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (mem_regwrite && mem_rd != NOFWD && mem_rd == ex_src[i*AW +: AW]) begin
                fwd_sel[2*i +: 2] = FWD_MEM;
            end else if (wb_regwrite && wb_rd != NOFWD && wb_rd == ex_src[i*AW +: AW]) begin
                fwd_sel[2*i +: 2] = FWD_WB;
            end
        end
    end

    always_comb begin
        lu_hit = 1'b0;
        sb_hit = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (id_src_vld[i]) begin
                if (ex_memread && ex_regwrite && ex_rd != NOFWD && ex_rd == id_src[i*AW +: AW])
                    lu_hit = 1'b1;
                if (id_src[i*AW +: AW] != NOFWD &&
                    (busy[id_src[i*AW +: AW]] || (mc_issue && mc_rd == id_src[i*AW +: AW])))
                    sb_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (lu_hit) begin
                    lat_stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = LSTALL;
                        cnt_d   = CNT_W'(LOAD_LAT - 1);
                    end
                end
            end
            LSTALL: begin
                lat_stall = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // A taken branch squashes the stalled instruction, so the wait is abandoned.
        if (branch_taken) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign flush  = branch_taken;
    assign stall  = !branch_taken && (lat_stall || sb_hit);
    assign bubble = stall;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: forwarding vector table, directed
// multicycle sequences, then randomized traffic against a behavioural model.
module tb_hazard_fwd_unit;

    localparam int AW = 5;
    localparam int NSRC = 2;
    localparam int NOFWD = 31;
    localparam int LL = 3;
    localparam int MP = 2;

    logic                clk;
    logic                rst_n;
    logic [NSRC*AW-1:0]  id_src;
    logic [NSRC-1:0]     id_src_vld;
    logic [NSRC*AW-1:0]  ex_src;
    logic [AW-1:0]       ex_rd, mem_rd, wb_rd;
    logic                ex_regwrite, mem_regwrite, wb_regwrite;
    logic                ex_memread;
    logic                mc_issue;
    logic [AW-1:0]       mc_rd;
    logic                mc_done;
    logic [AW-1:0]       mc_done_rd;
    logic                branch_taken;
    logic [2*NSRC-1:0]   fwd_sel;
    logic                stall, bubble, flush, mc_full;
    logic [3:0]          mc_pending;

    int n_checks = 0;
    int n_errors = 0;

    hazard_fwd_unit #(
        .AW(AW), .NSRC(NSRC), .NOFWD_REG(NOFWD), .LOAD_LAT(LL), .MAX_PEND(MP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_src(id_src), .id_src_vld(id_src_vld), .ex_src(ex_src),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .ex_memread(ex_memread), .mc_issue(mc_issue), .mc_rd(mc_rd),
        .mc_done(mc_done), .mc_done_rd(mc_done_rd), .branch_taken(branch_taken),
        .fwd_sel(fwd_sel), .stall(stall), .bubble(bubble), .flush(flush),
        .mc_full(mc_full), .mc_pending(mc_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_src = '0; id_src_vld = '0; ex_src = '0;
        ex_rd = '0; mem_rd = '0; wb_rd = '0;
        ex_regwrite = 0; mem_regwrite = 0; wb_regwrite = 0; ex_memread = 0;
        mc_issue = 0; mc_rd = '0; mc_done = 0; mc_done_rd = '0; branch_taken = 0;
    endtask

    // Forwarding vectors
    typedef struct {
        logic [4:0] s0, s1, mrd, wrd;
        logic       mwe, wwe;
        logic [3:0] exp_fwd;
    } fwd_vec_t;
    fwd_vec_t vecs[8];

    // Behavioural model state
    bit m_busy[32];
    int m_pend;
    int m_rem;  // stall cycles still owed to an earlier load-use

    function automatic logic [4:0] rreg();
        if ($urandom_range(0, 7) == 0) return 5'd31;
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [3:0] model_fwd(input logic [9:0] src, input logic [4:0] mrd,
                                             input logic mwe, input logic [4:0] wrd, input logic wwe);
        logic [3:0] r;
        logic [4:0] s;
        r = '0;
        for (int k = 0; k < NSRC; k++) begin
            s = src[k*AW +: AW];
            if (mwe && mrd != 5'd31 && mrd == s) r[2*k +: 2] = 2'b10;
            else if (wwe && wrd != 5'd31 && wrd == s) r[2*k +: 2] = 2'b01;
        end
        return r;
    endfunction

    initial begin
        logic [4:0] s;
        bit lu, sb, done_ok, issue_ok, exp_stall;

        // ---------------- reset state
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", stall, 0);
        check("rst_bubble", bubble, 0);
        check("rst_flush", flush, 0);
        check("rst_full", mc_full, 0);
        check("rst_pending", mc_pending, 0);
        rst_n = 1'b1;
        step();

        // ---------------- forwarding table
        vecs[0] = '{s0:3,  s1:0,  mrd:3,  wrd:3,  mwe:1, wwe:1, exp_fwd:4'b0010};
        vecs[1] = '{s0:3,  s1:0,  mrd:3,  wrd:3,  mwe:0, wwe:1, exp_fwd:4'b0001};
        vecs[2] = '{s0:31, s1:0,  mrd:31, wrd:31, mwe:1, wwe:1, exp_fwd:4'b0000};
        vecs[3] = '{s0:4,  s1:6,  mrd:6,  wrd:4,  mwe:1, wwe:1, exp_fwd:4'b1001};
        vecs[4] = '{s0:6,  s1:6,  mrd:6,  wrd:6,  mwe:0, wwe:1, exp_fwd:4'b0101};
        vecs[5] = '{s0:2,  s1:2,  mrd:2,  wrd:2,  mwe:0, wwe:0, exp_fwd:4'b0000};
        vecs[6] = '{s0:0,  s1:9,  mrd:0,  wrd:9,  mwe:1, wwe:1, exp_fwd:4'b0110};
        vecs[7] = '{s0:31, s1:31, mrd:5,  wrd:31, mwe:1, wwe:1, exp_fwd:4'b0000};
        for (int v = 0; v < 8; v++) begin
            ex_src = {vecs[v].s1, vecs[v].s0};
            mem_rd = vecs[v].mrd; wb_rd = vecs[v].wrd;
            mem_regwrite = vecs[v].mwe; wb_regwrite = vecs[v].wwe;
            #1;
            check($sformatf("fwd_vec%0d", v), fwd_sel, vecs[v].exp_fwd);
        end
        set_idle();
        step();

        // ---------------- load-use, LOAD_LAT=3
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_src = {5'd5, 5'd0}; id_src_vld = 2'b10;
        #1;
        check("lu_c1_stall", stall, 1);
        check("lu_c1_bubble", bubble, 1);
        step(); set_idle(); #1;
        check("lu_c2_stall", stall, 1);
        step(); #1;
        check("lu_c3_stall", stall, 1);
        check("lu_c3_bubble", bubble, 1);
        step(); #1;
        check("lu_c4_stall", stall, 0);
        check("lu_c4_bubble", bubble, 0);
        step();

        // ---------------- scoreboard hold until after mc_done
        mc_issue = 1; mc_rd = 7; id_src = {5'd0, 5'd7}; id_src_vld = 2'b01;
        #1; check("sb_issue_stall", stall, 1);
        step(); mc_issue = 0; #1;
        check("sb_busy_stall", stall, 1);
        check("sb_pend1", mc_pending, 1);
        step(); #1; check("sb_hold_stall", stall, 1);
        step(); mc_done = 1; mc_done_rd = 7; #1;
        check("sb_done_cycle_stall", stall, 1);
        step(); mc_done = 0; #1;
        check("sb_after_done_stall", stall, 0);
        check("sb_pend0", mc_pending, 0);
        step(); set_idle();

        // ---------------- full boundary, MAX_PEND=2
        mc_issue = 1; mc_rd = 1; #1; check("full_i1", mc_full, 0);
        step(); mc_rd = 2; #1;
        check("full_i2", mc_full, 0);
        check("full_i2_pend", mc_pending, 1);
        step(); mc_rd = 3; #1;
        check("full_i3", mc_full, 1);
        check("full_i3_pend", mc_pending, 2);
        step(); mc_issue = 0; id_src = {5'd0, 5'd3}; id_src_vld = 2'b01; #1;
        check("full_r3_not_busy", stall, 0);
        check("full_pend_hold", mc_pending, 2);
        step(); id_src_vld = 2'b00;
        mc_issue = 1; mc_rd = 4; mc_done = 1; mc_done_rd = 1;
        step(); mc_issue = 0; mc_done = 0; #1;
        check("full_swap_pend", mc_pending, 2);
        check("full_swap_full", mc_full, 1);
        id_src = {5'd0, 5'd1}; id_src_vld = 2'b01; #1;
        check("full_r1_cleared", stall, 0);
        id_src = {5'd0, 5'd4}; #1;
        check("full_r4_busy", stall, 1);
        id_src_vld = 2'b00; mc_done = 1; mc_done_rd = 2;
        step(); mc_done_rd = 4;
        step(); mc_done = 0; #1;
        check("full_drain_pend", mc_pending, 0);
        check("full_drain_full", mc_full, 0);
        step(); set_idle();

        // ---------------- branch flush aborts LSTALL
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_src = {5'd5, 5'd0}; id_src_vld = 2'b10;
        #1; check("br_detect_stall", stall, 1);
        step(); set_idle(); branch_taken = 1; #1;
        check("br_flush", flush, 1);
        check("br_stall", stall, 0);
        check("br_bubble", bubble, 0);
        step(); branch_taken = 0; #1;
        check("br_next_stall", stall, 0);
        check("br_next_flush", flush, 0);
        step();

        // ---------------- async reset mid-stall
        mc_issue = 1; mc_rd = 9;
        step(); mc_issue = 0;
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_src = {5'd5, 5'd0}; id_src_vld = 2'b10;
        #1; check("ar_detect_stall", stall, 1);
        step(); ex_memread = 0; ex_regwrite = 0; id_src = {5'd0, 5'd9}; id_src_vld = 2'b01; #1;
        check("ar_pre_stall", stall, 1);
        check("ar_pre_pend", mc_pending, 1);
        rst_n = 1'b0; #1;
        check("ar_stall", stall, 0);
        check("ar_bubble", bubble, 0);
        check("ar_pend", mc_pending, 0);
        step(); step(); rst_n = 1'b1; #1;
        check("ar_release_stall", stall, 0);
        step(); #1;
        check("ar_no_resume", stall, 0);
        set_idle();

        // ---------------- randomized traffic vs behavioural model
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        foreach (m_busy[k]) m_busy[k] = 0;
        m_pend = 0;
        m_rem = 0;
        for (int c = 0; c < 400; c++) begin
            id_src = {rreg(), rreg()};
            id_src_vld = 2'($urandom_range(0, 3));
            ex_src = {rreg(), rreg()};
            ex_rd = rreg(); mem_rd = rreg(); wb_rd = rreg();
            ex_regwrite = 1'($urandom_range(0, 1));
            mem_regwrite = 1'($urandom_range(0, 1));
            wb_regwrite = 1'($urandom_range(0, 1));
            ex_memread = ($urandom_range(0, 3) == 0);
            mc_issue = ($urandom_range(0, 2) == 0);
            mc_rd = rreg();
            mc_done = ($urandom_range(0, 2) == 0);
            mc_done_rd = rreg();
            branch_taken = ($urandom_range(0, 9) == 0);

            lu = 0; sb = 0;
            for (int k = 0; k < NSRC; k++) begin
                s = id_src[k*AW +: AW];
                if (id_src_vld[k]) begin
                    if (ex_memread && ex_regwrite && ex_rd != 5'd31 && ex_rd == s) lu = 1;
                    if (s != 5'd31 && (m_busy[s] || (mc_issue && mc_rd == s))) sb = 1;
                end
            end
            exp_stall = !branch_taken && ((m_rem > 0) || lu || sb);
            #1;
            check("rnd_fwd", fwd_sel, model_fwd(ex_src, mem_rd, mem_regwrite, wb_rd, wb_regwrite));
            check("rnd_stall", stall, exp_stall);
            check("rnd_bubble", bubble, exp_stall);
            check("rnd_flush", flush, branch_taken);
            check("rnd_full", mc_full, (m_pend == MP));
            check("rnd_pend", mc_pending, m_pend);

            if (branch_taken) m_rem = 0;
            else if (m_rem > 0) m_rem--;
            else if (lu) m_rem = LL - 1;
            done_ok = mc_done && m_busy[mc_done_rd] && m_pend > 0;
            issue_ok = mc_issue && mc_rd != 5'd31 && (m_pend < MP || done_ok);
            m_pend = m_pend + int'(issue_ok) - int'(done_ok);
            if (done_ok) m_busy[mc_done_rd] = 0;
            if (issue_ok) m_busy[mc_rd] = 1;
            step();
        end
        set_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
